line_tracker_ctrl: RTL
======================

# line_tracker_ctrl

Parametrised line-following decision block for the car: it takes NUM_SENSORS reflective tracker inputs, debounces each one, and computes a signed position error from the outermost active sensors. It drives the 2-bit motion state plus a steering magnitude to the motor controller. A lost-line FSM searches toward the side where the line was last seen before stopping. With NUM_SENSORS=3 and no debounce or search, the state output reduces to the team's original 3-sensor tracker policy.

## Interface
- NUM_SENSORS, 5: sensor count; odd, ≥3; index 0 = leftmost.
- DEBOUNCE_CYCLES, 4: consecutive synchronised disagreeing samples needed to flip a filtered sensor; ≥1.
- LOST_TIMEOUT, 1000: cycles spent in SEARCH before STOP; ≥1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- sensor  in  NUM_SENSORS  raw tracker inputs, asynchronous, 1 = line detected.
- state  out  2  motion command: 00 turn_left, 01 turn_right, 10 go_straight, 11 stop.
- steer_mag  out  $clog2(NUM_SENSORS)  |error|; 0 when straight or stopped.
- lost  out  1  high while FSM is in SEARCH.

## Operation
- Per sensor:
  - 2-flop synchroniser.
  - Counter of consecutive cycles where the synchronised value ≠ the filtered value. The counter clears on any match.
  - When the counter reaches DEBOUNCE_CYCLES, filtered ← synchronised and the counter clears.
- Error: let lo/hi be the lowest/highest index with filtered=1. error = (lo+hi) − (NUM_SENSORS−1), signed, width $clog2(NUM_SENSORS)+1, range ±(NUM_SENSORS−1).
  - error>0 → turn_right; error<0 → turn_left; error=0 → go_straight.
  - steer_mag = |error|.
- last_dir register: updated only in TRACK. Holds +1/−1/0 from the error sign.
- FSM states: STOP, TRACK, SEARCH.
  - STOP: state=11, steer_mag=0. Goes to TRACK when any filtered=1. STOP is exited only by an active sensor.
  - TRACK: state/steer_mag from error. Goes to SEARCH when all filtered=0.
  - SEARCH: state=turn_right if last_dir=+1, turn_left if −1, go_straight if 0. steer_mag=NUM_SENSORS−1 when turning, 0 when straight. lost=1. Timer increments each cycle.
    - Any filtered=1 → TRACK; the timer clears.
    - Timer = LOST_TIMEOUT−1 with all filtered=0 → STOP.
    - A sensor becoming active on the timeout cycle wins → TRACK.
- All sensors active (cross-line marker): error=0 → go_straight.

## Timing
- Reset values:
  - state=11
  - steer_mag=0
  - lost=0
  - FSM=STOP
  - last_dir=0
  - synchronisers, filtered bits, debounce counters and lost timer all 0
- Reset mid-operation: all of the above restored on the next rising edge. No partial search continues.
- Latency from a stable raw change to the state output: 2 (sync) + DEBOUNCE_CYCLES (filter) + 1 (output register) = DEBOUNCE_CYCLES+3 rising edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches the output.
- All outputs are registered and change only on rising clk. FSM transitions take effect at the same edge as the corresponding output.
- SEARCH lasts exactly LOST_TIMEOUT cycles (lost=1 for LOST_TIMEOUT cycles), then state=11.
- Lost timer width: $clog2(LOST_TIMEOUT+1). No wrap, because it clears on leaving SEARCH.

## Configuration
- LINE_TRACKER_SEARCH_EN:
  - Defined: SEARCH state, lost timer and last_dir are present, as described above.
  - Undefined: TRACK goes directly to STOP when all filtered=0. lost is tied 0. The timer and last_dir are not synthesised. LOST_TIMEOUT is ignored.

## Structure
- Package tracker_pkg holds:
  - state encodings TURN_LEFT, TURN_RIGHT, GO_STRAIGHT, STOP_STATE
  - FSM state typedef (STOP, TRACK, SEARCH)
- Sub-module sensor_debounce:
  - parameter DEBOUNCE_CYCLES
  - ports clk, reset, raw, filtered
  - contains the synchroniser and counter
  - instantiated NUM_SENSORS times via generate
- The top level holds the lo/hi priority encoders, error arithmetic, FSM and output registers.

## Test plan
Common settings: NUM_SENSORS=5, DEBOUNCE_CYCLES=4, LOST_TIMEOUT=16, macro defined unless stated.
1. Release reset with sensor=00000 for 50 cycles → state=11, lost=0 throughout. Drive 00100 → state=10, steer_mag=0 exactly 7 edges after the change.
2. sensor=00011 (indices 0,1) → error=−3 → state=00, steer_mag=3. sensor=11000 → error=+7−4=+3 → state=01, steer_mag=3. sensor=11111 → state=10.
3. From TRACK with sensor=11000, drop to 00000 → lost=1, state=01, steer_mag=4 for 16 cycles, then state=11, lost=0. Re-apply 00100 on cycle 10 of SEARCH instead → TRACK, state=10, lost=0.
4. 3-cycle pulse 00000→00100→00000 in STOP → state stays 11. Same pulse lasting 4 cycles → state=10.
5. Assert reset (0) for 1 cycle during SEARCH → next edge: state=11, lost=0, steer_mag=0.
6. Macro undefined: TRACK with 00110, drop to 00000 → state=11 one edge after the filtered bits clear; lost never asserts.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared encodings for the line tracker: motion command codes and the lost-line FSM states.
package tracker_pkg;

  localparam logic [1:0] TURN_LEFT   = 2'b00;
  localparam logic [1:0] TURN_RIGHT  = 2'b01;
  localparam logic [1:0] GO_STRAIGHT = 2'b10;
  localparam logic [1:0] STOP_STATE  = 2'b11;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    TRACK  = 2'd1,
    SEARCH = 2'd2
  } fsm_t;

endpackage

// File: rtl/sensor_debounce.sv
// One tracker input: 2-flop synchroniser followed by a consecutive-disagreement filter.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  // The counter only has to hold DEBOUNCE_CYCLES-1; the final disagreeing sample flips the output.
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign filtered = r_filt;

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line-following decision block: debounced sensors -> position error -> motion command.
// Define LINE_TRACKER_SEARCH_EN to add the SEARCH state (lost timer, last_dir) between TRACK and STOP.
module line_tracker_ctrl #(
  parameter int NUM_SENSORS     = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOST_TIMEOUT    = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SENSORS-1:0]         sensor,
  output logic [1:0]                     state,
  output logic [$clog2(NUM_SENSORS)-1:0] steer_mag,
  output logic                           lost
);

  import tracker_pkg::*;

  localparam int IW = $clog2(NUM_SENSORS);
  localparam int EW = IW + 1;

  logic [NUM_SENSORS-1:0] w_filt;
  logic                   w_any;
  logic [IW-1:0]          w_lo;
  logic [IW-1:0]          w_hi;
  logic signed [EW:0]     w_err;
  logic signed [EW:0]     w_err_neg;
  logic [IW-1:0]          w_err_mag;
  logic [1:0]             w_track_state;
  logic signed [1:0]      w_err_sign;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_deb
      sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .raw      (sensor[gi]),
        .filtered (w_filt[gi])
      );
    end
  endgenerate

  assign w_any = |w_filt;

  // Outermost active sensors; the result is only meaningful when w_any is set.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (w_filt[i]) w_lo = IW'(i);
    end
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (w_filt[i]) w_hi = IW'(i);
    end
  end

  assign w_err     = $signed({2'b00, w_lo}) + $signed({2'b00, w_hi}) - $signed((EW+1)'(NUM_SENSORS - 1));
  assign w_err_neg = -w_err;
  assign w_err_mag = w_err[EW] ? w_err_neg[IW-1:0] : w_err[IW-1:0];

  always_comb begin
    w_track_state = GO_STRAIGHT;
    w_err_sign    = 2'sd0;
    if (w_err[EW]) begin
      w_track_state = TURN_LEFT;
      w_err_sign    = -2'sd1;
    end else if (w_err != '0) begin
      w_track_state = TURN_RIGHT;
      w_err_sign    = 2'sd1;
    end
  end

  fsm_t          r_fsm;
  fsm_t          w_fsm_next;
  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [IW-1:0] r_mag;
  logic [IW-1:0] w_mag_next;
  logic          r_lost;
  logic          w_lost_next;

`ifdef LINE_TRACKER_SEARCH_EN
  localparam int TW = $clog2(LOST_TIMEOUT + 1);
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_timer_next;
  logic signed [1:0] r_last_dir;
  logic signed [1:0] w_last_dir_next;
`endif

  // Outputs are computed for the state being entered so they change on the same edge as the FSM.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_state_next = STOP_STATE;
    w_mag_next   = '0;
    w_lost_next  = 1'b0;
`ifdef LINE_TRACKER_SEARCH_EN
    w_timer_next    = '0;
    w_last_dir_next = r_last_dir;
`endif
    unique case (r_fsm)
      STOP: begin
        if (w_any) w_fsm_next = TRACK;
      end
      TRACK: begin
`ifdef LINE_TRACKER_SEARCH_EN
        if (!w_any) w_fsm_next = SEARCH;
`else
        if (!w_any) w_fsm_next = STOP;
`endif
      end
      SEARCH: begin
`ifdef LINE_TRACKER_SEARCH_EN
        if (w_any) begin
          w_fsm_next = TRACK;
        end else if (r_timer == TW'(LOST_TIMEOUT - 1)) begin
          w_fsm_next = STOP;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
`else
        w_fsm_next = STOP;
`endif
      end
      default: w_fsm_next = STOP;
    endcase

    case (w_fsm_next)
      TRACK: begin
        w_state_next = w_track_state;
        w_mag_next   = w_err_mag;
`ifdef LINE_TRACKER_SEARCH_EN
        w_last_dir_next = w_err_sign;
`endif
      end
`ifdef LINE_TRACKER_SEARCH_EN
      SEARCH: begin
        w_lost_next = 1'b1;
        if (r_last_dir > 2'sd0) begin
          w_state_next = TURN_RIGHT;
          w_mag_next   = IW'(NUM_SENSORS - 1);
        end else if (r_last_dir < 2'sd0) begin
          w_state_next = TURN_LEFT;
          w_mag_next   = IW'(NUM_SENSORS - 1);
        end else begin
          w_state_next = GO_STRAIGHT;
        end
      end
`endif
      default: begin
        w_state_next = STOP_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm   <= STOP;
      r_state <= STOP_STATE;
      r_mag   <= '0;
      r_lost  <= 1'b0;
`ifdef LINE_TRACKER_SEARCH_EN
      r_timer    <= '0;
      r_last_dir <= 2'sd0;
`endif
    end else begin
      r_fsm   <= w_fsm_next;
      r_state <= w_state_next;
      r_mag   <= w_mag_next;
      r_lost  <= w_lost_next;
`ifdef LINE_TRACKER_SEARCH_EN
      r_timer    <= w_timer_next;
      r_last_dir <= w_last_dir_next;
`endif
    end
  end

  assign state     = r_state;
  assign steer_mag = r_mag;
  assign lost      = r_lost;

`ifndef LINE_TRACKER_SEARCH_EN
  logic w_unused_sign;
  assign w_unused_sign = ^w_err_sign;
`endif

endmodule
